multiply_backward: RTL



---
 rtl/multiply_pkg.sv | 28 ++
 rtl/fixed_multiply.sv | 43 ++++
 rtl/multiply_backward.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/multiply_pkg.sv
// Shared definitions for the multiply / multiply_backward units:
// backward-pass state encoding and Q-format saturation/rounding constants.
package multiply_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOADED = 3'd1,
        ST_MUL0   = 3'd2,
        ST_MUL1   = 3'd3,
        ST_DONE   = 3'd4
    } mulb_state_t;

    // Largest representable signed value of an argw-bit quantity.
    function automatic logic signed [63:0] q_max(input int argw);
        return (64'sd1 <<< (argw - 1)) - 64'sd1;
    endfunction

    // Smallest representable signed value of an argw-bit quantity.
    function automatic logic signed [63:0] q_min(input int argw);
        return -(64'sd1 <<< (argw - 1));
    endfunction

    // Half an LSB of the shifted result, added before the shift for round-half-up.
    function automatic logic signed [63:0] round_const(input int frac);
        return 64'sd1 <<< (frac - 1);
    endfunction

endpackage

// File: rtl/fixed_multiply.sv
// Combinational signed fixed-point multiply: full product, optional
// round-half-up (MULTIPLY_BACKWARD_ROUND_EN), arithmetic shift by FRAC,
// saturation back to ARGW bits. Truncates (floor) when the macro is undefined.
module fixed_multiply
    import multiply_pkg::*;
#(
    parameter int ARGW = 16,
    parameter int FRAC = 8
) (
    input  logic signed [ARGW-1:0] a_i,
    input  logic signed [ARGW-1:0] b_i,
    output logic signed [ARGW-1:0] y_o
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int PW = 2 * ARGW + 1;
    localparam logic signed [PW-1:0] MAX_S = PW'(q_max(ARGW));
    localparam logic signed [PW-1:0] MIN_S = PW'(q_min(ARGW));
`ifdef MULTIPLY_BACKWARD_ROUND_EN
    localparam logic signed [PW-1:0] RND_S = PW'(round_const(FRAC));
`else
    localparam logic signed [PW-1:0] RND_S = '0;
`endif

    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] biased_s;
    logic signed [PW-1:0] shifted_s;

    // Multiply, bias, shift and clamp into the output range.
    always_comb begin
        prod_s    = PW'(a_i) * PW'(b_i);
        biased_s  = prod_s + RND_S;
        shifted_s = biased_s >>> FRAC;
        if (shifted_s > MAX_S) begin
            y_o = MAX_S[ARGW-1:0];
        end else if (shifted_s < MIN_S) begin
            y_o = MIN_S[ARGW-1:0];
        end else begin
            y_o = shifted_s[ARGW-1:0];
        end
    end

endmodule

// File: rtl/multiply_backward.sv
// Backward pass of a product node: holds operands a0/a1, accepts an error e
// and returns p0 = e*a1 (low half) and p1 = e*a0 (high half) using one
// shared fixed_multiply over two cycles.
// Optional feature: MULTIPLY_BACKWARD_ROUND_EN selects round-half-up.
module multiply_backward
    import multiply_pkg::*;
#(
    parameter int ARGW = 16,
    parameter int FRAC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arg_valid,
    output logic                arg_ready,
    input  logic [2*ARGW-1:0]   arg_data,
    input  logic                err_valid,
    output logic                err_ready,
    input  logic [ARGW-1:0]     err_data,
    output logic                prop_valid,
    input  logic                prop_ready,
    output logic [2*ARGW-1:0]   prop_data
);

    mulb_state_t              state_q, state_d;
    logic                     held_q, held_d;
    logic signed [ARGW-1:0]   a0_q, a0_d;
    logic signed [ARGW-1:0]   a1_q, a1_d;
    logic signed [ARGW-1:0]   e_q, e_d;
    logic [2*ARGW-1:0]        p_q, p_d;
    logic signed [ARGW-1:0]   mul_b_s;
    logic signed [ARGW-1:0]   mul_y_s;
    logic                     arg_fire_s;
    logic                     err_fire_s;

    // Handshake outputs; forced low while reset is asserted.
    always_comb begin
        arg_ready  = 1'b0;
        err_ready  = 1'b0;
        prop_valid = 1'b0;
        if (rst) begin
            arg_ready  = 1'b0;
            err_ready  = 1'b0;
            prop_valid = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:   arg_ready  = 1'b1;
                ST_LOADED: begin
                    err_ready = held_q;
                    // A pending error wins and uses the operands already held.
                    arg_ready = ~err_valid;
                end
                ST_DONE:   prop_valid = 1'b1;
                default:   prop_valid = 1'b0;
            endcase
        end
    end

    assign arg_fire_s = arg_valid & arg_ready;
    assign err_fire_s = err_valid & err_ready;
    assign prop_data  = p_q;

    // Shared multiplier: MUL0 uses a1 (for p0), MUL1 uses a0 (for p1).
    always_comb begin
        if (state_q == ST_MUL0) begin
            mul_b_s = a1_q;
        end else begin
            mul_b_s = a0_q;
        end
    end

    fixed_multiply #(
        .ARGW (ARGW),
        .FRAC (FRAC)
    ) u_mul (
        .a_i (e_q),
        .b_i (mul_b_s),
        .y_o (mul_y_s)
    );

    // Next-state and datapath register update.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        e_d     = e_q;
        p_d     = p_q;
        case (state_q)
            ST_IDLE: begin
                if (arg_fire_s) begin
                    a0_d    = arg_data[ARGW-1:0];
                    a1_d    = arg_data[2*ARGW-1:ARGW];
                    held_d  = 1'b1;
                    state_d = ST_LOADED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOADED: begin
                if (err_fire_s) begin
                    e_d     = err_data;
                    state_d = ST_MUL0;
                end else if (arg_fire_s) begin
                    a0_d    = arg_data[ARGW-1:0];
                    a1_d    = arg_data[2*ARGW-1:ARGW];
                    state_d = ST_LOADED;
                end else begin
                    state_d = ST_LOADED;
                end
            end
            ST_MUL0: begin
                p_d[ARGW-1:0] = mul_y_s;
                state_d       = ST_MUL1;
            end
            ST_MUL1: begin
                p_d[2*ARGW-1:ARGW] = mul_y_s;
                state_d            = ST_DONE;
            end
            ST_DONE: begin
                if (prop_ready) begin
                    state_d = ST_LOADED;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            held_q  <= 1'b0;
            a0_q    <= '0;
            a1_q    <= '0;
            e_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            e_q     <= e_d;
            p_q     <= p_d;
        end
    end

endmodule
